g_ecc_scrubber: RTL and testbench
=================================

# g_ecc_scrubber

Memory scrubbing controller for SECDED-protected storage built on G_HammingDecoder. On a start pulse it sweeps a word range of an external synchronous RAM, sending each stored codeword through one internal G_HammingDecoder instance. It writes corrected codewords back and logs correctable and uncorrectable errors. Memory access is shared with the functional path through a request/grant handshake.

## Interface
- p_dataSize, 10, payload bits per word; passed to the internal G_HammingDecoder.
- p_zeroWordDetection, 1, passed to the decoder; when 1, an all-zero codeword counts as uncorrectable.
- p_addrWidth, 8, RAM address width.
- p_depth, 256, number of words swept (addresses 0..p_depth-1); must be ≤ 2**p_addrWidth.
- p_cntWidth, 16, width of the error counters.
- Derived: W = p_dataSize + G_RD_PROJ_functions::ECC_bitsQnty(p_dataSize) + 1, the codeword width (15 for the defaults).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  one-cycle pulse; starts a sweep when idle.
- abort  in  1  level; ends the sweep at the next word boundary.
- busy  out  1  high from the cycle after an accepted start until the cycle DONE is exited.
- done  out  1  one-cycle pulse when a sweep ends (normally or by abort).
- memReq  out  1  scrubber wants the RAM this cycle.
- memGnt  in  1  RAM owned by the scrubber this cycle.
- memAddr  out  p_addrWidth  current word address.
- memRdEn  out  1  read strobe; asserted only when memReq&memGnt.
- memRdData  in  W  read data, valid one cycle after memRdEn.
- memWrEn  out  1  write strobe; asserted only when memReq&memGnt.
- memWrData  out  W  corrected codeword (decoder dataOutWithECC).
- corrCnt  out  p_cntWidth  saturating count of correctable errors, including overall-parity-bit-only errors.
- uncorrCnt  out  p_cntWidth  saturating count of uncorrectable words.
- lastErrAddr  out  p_addrWidth  address of the most recent word with any error.
- errSticky  out  1  set on any uncorrectable word; cleared by start or rst.

## Operation
- States: IDLE, RD, CAP, CHK, WB, NXT, DONE.
- IDLE:
  - On start: address←0, corrCnt/uncorrCnt/errSticky←0, go to RD.
  - start while not in IDLE is ignored.
- RD:
  - memReq=1.
  - If memGnt: memRdEn=1, go to CAP. Otherwise hold in RD.
- CAP: register memRdData into codeReg. The decoder is combinational on codeReg.
- CHK: classify the decoder outputs and act:
  - error=0 → NXT.
  - error=1, uncorrectable=0 → corrCnt++, lastErrAddr←addr, go to WB.
  - uncorrectable=1 → uncorrCnt++, lastErrAddr←addr, errSticky←1, go to NXT. No write-back; RAM contents stay untouched.
- WB:
  - memReq=1, memWrData=registered dataOutWithECC.
  - If memGnt: memWrEn=1, go to NXT. Otherwise hold.
- NXT:
  - If abort, or addr==p_depth-1 → DONE.
  - Otherwise addr++ and go to RD.
- DONE: done=1 for one cycle, then IDLE. Counters and lastErrAddr hold until the next start.
- Counters saturate at all-ones and never wrap.
- memReq is low in IDLE, CAP, CHK, NXT and DONE. memRdEn and memWrEn are never high together.

## Timing
- With memGnt held high: a clean word takes 4 cycles (RD, CAP, CHK, NXT); a corrected word takes 5 (adds WB).
- Full clean sweep: 4·p_depth + 1 cycles from the cycle after start to the done pulse inclusive.
- Each cycle memGnt is low in RD or WB adds exactly one cycle. memAddr and memWrData stay stable while waiting.
- abort is sampled only in NXT. A word in progress always completes, including its write-back.
- Simultaneous start and abort in IDLE: start is taken; abort then ends the sweep at the first NXT.
- rst at any cycle, including mid-WB, forces IDLE on the next edge. Reset values:
  - busy, done, memReq, memRdEn, memWrEn, errSticky = 0.
  - memAddr, memWrData, corrCnt, uncorrCnt, lastErrAddr, codeReg = 0.
- Address wrap is not possible; the sweep ends at p_depth-1.

## Test plan
- Clean RAM, p_depth=4, memGnt=1: start → reads at addresses 0..3, no memWrEn, done at cycle 17 after start, all counters 0.
- Single-bit flip (bit 2) in word at address 2: one write at address 2 with the original codeword, corrCnt=1, lastErrAddr=2, errSticky=0.
- Double-bit flip at address 1, plus all-zero word at address 3 with p_zeroWordDetection=1: no writes, uncorrCnt=2, lastErrAddr=3, errSticky=1.
- Toggle memGnt 0/1 every cycle during a sweep with one correctable word: strobes occur only in granted cycles, address and write data stay stable while stalled, results match the memGnt=1 run.
- Assert abort during CAP of address 1: word 1 completes, done pulses immediately after its NXT, no read of address 2.
- Assert rst during WB with memGnt=0: next cycle all outputs at reset values, no memWrEn issued; a new start sweeps from address 0.

Source files
------------

// File: rtl/g_ecc_scrubber.sv
// SECDED memory scrubber: sweeps a RAM word range, corrects single-bit
// errors in place through a Hamming decoder and logs every error it finds.

package G_RD_PROJ_functions;
  // Hamming check bits needed to cover data_size payload bits
  // (smallest r with 2**r >= data_size + r + 1).
  function automatic int ECC_bitsQnty(input int data_size);
    int r;
    r = 1;
    while ((2 ** r) < (data_size + r + 1)) r = r + 1;
    return r;
  endfunction
endpackage

// Codeword layout: bit 0 is the overall parity bit, bits 1..N are Hamming
// positions 1..N with check bits at the power-of-two positions.
module G_HammingDecoder #(
  parameter int p_dataSize          = 10,
  parameter int p_zeroWordDetection = 1,
  localparam int R = G_RD_PROJ_functions::ECC_bitsQnty(p_dataSize),
  localparam int N = p_dataSize + R,
  localparam int W = N + 1
) (
  input  logic [W-1:0] dataIn,
  output logic [W-1:0] dataOutWithECC,
  output logic         error,
  output logic         uncorrectable
);

  logic [R-1:0] syndrome;
  logic         parity;
  logic         hit;

  // Syndrome plus overall parity classify the word; a single flip is undone.
  always_comb begin
    syndrome       = '0;
    parity         = ^dataIn;
    hit            = 1'b0;
    error          = 1'b0;
    uncorrectable  = 1'b0;
    dataOutWithECC = dataIn;
    for (int i = 1; i <= N; i++) begin
      if (dataIn[i]) syndrome = syndrome ^ R'(i);
    end
    if ((p_zeroWordDetection != 0) && (dataIn == '0)) begin
      error         = 1'b1;
      uncorrectable = 1'b1;
    end else if (parity) begin
      error = 1'b1;
      if (syndrome == '0) begin
        dataOutWithECC[0] = ~dataIn[0];
      end else begin
        for (int i = 1; i <= N; i++) begin
          if (syndrome == R'(i)) begin
            dataOutWithECC[i] = ~dataIn[i];
            hit = 1'b1;
          end
        end
        // Syndrome points past the last position: cannot be a single flip.
        if (!hit) uncorrectable = 1'b1;
      end
    end else if (syndrome != '0) begin
      error         = 1'b1;
      uncorrectable = 1'b1;
    end
  end

endmodule

// state | meaning
// IDLE  | waiting for start
// RD    | requesting RAM, read strobe when granted
// CAP   | capturing read data into code_reg
// CHK   | classifying decoder result, updating counters
// WB    | requesting RAM, writing corrected codeword when granted
// NXT   | abort check / advance address
// DONE  | one-cycle done pulse
module g_ecc_scrubber #(
  parameter int p_dataSize          = 10,
  parameter int p_zeroWordDetection = 1,
  parameter int p_addrWidth         = 8,
  parameter int p_depth             = 256,
  parameter int p_cntWidth          = 16,
  localparam int W = p_dataSize + G_RD_PROJ_functions::ECC_bitsQnty(p_dataSize) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   memReq,
  input  logic                   memGnt,
  output logic [p_addrWidth-1:0] memAddr,
  output logic                   memRdEn,
  input  logic [W-1:0]           memRdData,
  output logic                   memWrEn,
  output logic [W-1:0]           memWrData,
  output logic [p_cntWidth-1:0]  corrCnt,
  output logic [p_cntWidth-1:0]  uncorrCnt,
  output logic [p_addrWidth-1:0] lastErrAddr,
  output logic                   errSticky
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_NXT  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [p_addrWidth-1:0] LAST_ADDR = p_addrWidth'(p_depth - 1);

  logic [2:0]   state;
  logic [W-1:0] code_reg;
  logic [W-1:0] dec_code;
  logic         dec_error;
  logic         dec_uncorr;

  G_HammingDecoder #(
    .p_dataSize          (p_dataSize),
    .p_zeroWordDetection (p_zeroWordDetection)
  ) u_dec (
    .dataIn         (code_reg),
    .dataOutWithECC (dec_code),
    .error          (dec_error),
    .uncorrectable  (dec_uncorr)
  );

  // Sweep sequencing, capture, error logging and write-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      memAddr     <= '0;
      code_reg    <= '0;
      memWrData   <= '0;
      corrCnt     <= '0;
      uncorrCnt   <= '0;
      lastErrAddr <= '0;
      errSticky   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            memAddr   <= '0;
            corrCnt   <= '0;
            uncorrCnt <= '0;
            errSticky <= 1'b0;
            state     <= S_RD;
          end
        end
        S_RD: begin
          if (memGnt) state <= S_CAP;
        end
        S_CAP: begin
          code_reg <= memRdData;
          state    <= S_CHK;
        end
        S_CHK: begin
          memWrData <= dec_code;
          if (dec_uncorr) begin
            if (uncorrCnt != '1) uncorrCnt <= uncorrCnt + 1'b1;
            lastErrAddr <= memAddr;
            errSticky   <= 1'b1;
            state       <= S_NXT;
          end else if (dec_error) begin
            if (corrCnt != '1) corrCnt <= corrCnt + 1'b1;
            lastErrAddr <= memAddr;
            state       <= S_WB;
          end else begin
            state <= S_NXT;
          end
        end
        S_WB: begin
          if (memGnt) state <= S_NXT;
        end
        S_NXT: begin
          if (abort || (memAddr == LAST_ADDR)) begin
            state <= S_DONE;
          end else begin
            memAddr <= memAddr + 1'b1;
            state   <= S_RD;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM strobes are decoded from state so they can only fire in granted cycles.
  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    memReq  = (state == S_RD) || (state == S_WB);
    memRdEn = (state == S_RD) && memGnt;
    memWrEn = (state == S_WB) && memGnt;
  end

endmodule

// File: tb/tb_g_ecc_scrubber.sv
// Directed bench for g_ecc_scrubber with a 4-word behavioural RAM.
module tb_g_ecc_scrubber;

  localparam int W     = 15;
  localparam int AW    = 8;
  localparam int CW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, memGnt;
  logic          busy, done, memReq, memRdEn, memWrEn, errSticky;
  logic [AW-1:0] memAddr, lastErrAddr;
  logic [W-1:0]  memRdData, memWrData;
  logic [CW-1:0] corrCnt, uncorrCnt;

  always #5 clk = ~clk;

  g_ecc_scrubber #(
    .p_dataSize(10), .p_zeroWordDetection(1), .p_addrWidth(AW),
    .p_depth(DEPTH), .p_cntWidth(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .memReq(memReq), .memGnt(memGnt), .memAddr(memAddr), .memRdEn(memRdEn),
    .memRdData(memRdData), .memWrEn(memWrEn), .memWrData(memWrData),
    .corrCnt(corrCnt), .uncorrCnt(uncorrCnt), .lastErrAddr(lastErrAddr),
    .errSticky(errSticky)
  );

  logic [W-1:0]  ram  [DEPTH];
  logic [W-1:0]  orig [DEPTH];
  logic [AW-1:0] rd_log [8];
  logic [AW-1:0] last_wr_addr, max_rd_addr, addr_prev;
  logic [W-1:0]  last_wr_data, wd_prev;
  logic          stall_prev;
  int n_rd, n_wr, n_viol, n_unstable, n_done, n_stall;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference SECDED encoder: bit 0 overall parity, Hamming positions 1..14.
  function automatic logic [W-1:0] enc(input logic [9:0] d);
    logic [W-1:0] c;
    logic b;
    int k;
    c = '0;
    k = 0;
    for (int i = 1; i <= 14; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 8; p = p * 2) begin
      b = 1'b0;
      for (int i = 1; i <= 14; i++) if (i != p && (i & p) != 0) b = b ^ c[i];
      c[p] = b;
    end
    c[0] = ^c[14:1];
    return c;
  endfunction

  // RAM model and bus monitor.
  always @(posedge clk) begin
    if ((memRdEn || memWrEn) && !(memReq && memGnt)) n_viol++;
    if (memRdEn && memWrEn) n_viol++;
    if (stall_prev && (memAddr != addr_prev || memWrData != wd_prev)) n_unstable++;
    stall_prev = memReq && !memGnt;
    if (memReq && !memGnt) n_stall++;
    addr_prev = memAddr;
    wd_prev   = memWrData;
    if (done) n_done++;
    if (memRdEn) begin
      memRdData <= ram[memAddr[1:0]];
      if (n_rd < 8) rd_log[n_rd] = memAddr;
      if (memAddr > max_rd_addr) max_rd_addr = memAddr;
      n_rd++;
    end
    if (memWrEn) begin
      ram[memAddr[1:0]] = memWrData;
      last_wr_addr = memAddr;
      last_wr_data = memWrData;
      n_wr++;
    end
  end

  task automatic clear_stats();
    n_rd = 0; n_wr = 0; n_viol = 0; n_unstable = 0; n_done = 0; n_stall = 0;
    max_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0; stall_prev = 1'b0;
  endtask

  task automatic load_clean();
    for (int i = 0; i < DEPTH; i++) ram[i] = orig[i];
  endtask

  // Pulse start and count cycles until done; cycle 1 is the first RD cycle.
  task automatic run_sweep(input int abort_cyc, input bit toggle, output int done_cyc);
    int cyc;
    @(negedge clk);
    clear_stats();
    start = 1'b1;
    cyc = 0;
    done_cyc = -1;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == abort_cyc) abort = 1'b1;
      if (toggle) memGnt = ~memGnt;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    check_val("done_seen", done_cyc >= 0, 1);
    abort  = 1'b0;
    memGnt = 1'b1;
  endtask

  initial begin
    int dc;
    orig[0] = enc(10'h155);
    orig[1] = enc(10'h0A3);
    orig[2] = enc(10'h3C6);
    orig[3] = enc(10'h2F1);
    load_clean();
    clear_stats();
    rst = 1'b1; start = 1'b0; abort = 1'b0; memGnt = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_ctrl", {busy, done, memReq, memRdEn, memWrEn, errSticky}, 0);
    check_val("rst_addr", memAddr, 0);
    check_val("rst_cnt", {corrCnt, uncorrCnt}, 0);
    rst = 1'b0;

    // Clean sweep
    run_sweep(-1, 1'b0, dc);
    check_val("clean_done_cyc", dc, 17);
    check_val("clean_rd", n_rd, 4);
    check_val("clean_rd_order", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]}, 32'h00010203);
    check_val("clean_wr", n_wr, 0);
    check_val("clean_cnt", {corrCnt, uncorrCnt}, 0);
    check_val("clean_sticky", errSticky, 0);
    @(negedge clk);
    check_val("clean_idle", {busy, done}, 0);
    check_val("clean_done_pulses", n_done, 1);

    // Single flip of bit 2 at address 2
    load_clean();
    ram[2] = orig[2] ^ 15'h0004;
    run_sweep(-1, 1'b0, dc);
    check_val("sbe_done_cyc", dc, 18);
    check_val("sbe_wr", n_wr, 1);
    check_val("sbe_wr_addr", last_wr_addr, 2);
    check_val("sbe_wr_data", last_wr_data, orig[2]);
    check_val("sbe_corr", corrCnt, 1);
    check_val("sbe_uncorr", uncorrCnt, 0);
    check_val("sbe_last", lastErrAddr, 2);
    check_val("sbe_sticky", errSticky, 0);

    // Double flip at address 1, all-zero word at address 3
    load_clean();
    ram[1] = orig[1] ^ 15'h0028;
    ram[3] = '0;
    run_sweep(-1, 1'b0, dc);
    check_val("dbe_wr", n_wr, 0);
    check_val("dbe_uncorr", uncorrCnt, 2);
    check_val("dbe_corr", corrCnt, 0);
    check_val("dbe_last", lastErrAddr, 3);
    check_val("dbe_sticky", errSticky, 1);
    check_val("dbe_ram1", ram[1], orig[1] ^ 15'h0028);
    check_val("dbe_ram3", ram[3], 0);

    // Grant toggling every cycle with one correctable word at address 2
    load_clean();
    ram[2] = orig[2] ^ 15'h0200;
    run_sweep(-1, 1'b1, dc);
    check_val("gnt_done_cyc", dc, 20);
    check_val("gnt_stalls", n_stall, 2);
    check_val("gnt_viol", n_viol, 0);
    check_val("gnt_stable", n_unstable, 0);
    check_val("gnt_wr", n_wr, 1);
    check_val("gnt_ram2", ram[2], orig[2]);
    check_val("gnt_corr", corrCnt, 1);
    check_val("gnt_last", lastErrAddr, 2);
    check_val("gnt_sticky_cleared", errSticky, 0);

    // Abort during CAP of address 1; word 1 has an overall-parity-only error
    load_clean();
    ram[1] = orig[1] ^ 15'h0001;
    run_sweep(6, 1'b0, dc);
    check_val("abort_done_cyc", dc, 10);
    check_val("abort_rd", n_rd, 2);
    check_val("abort_max_addr", max_rd_addr, 1);
    check_val("abort_wr", n_wr, 1);
    check_val("abort_ram1", ram[1], orig[1]);
    check_val("abort_corr", corrCnt, 1);

    // Reset during a stalled write-back of address 1
    load_clean();
    ram[1] = orig[1] ^ 15'h0040;
    @(negedge clk);
    clear_stats();
    start = 1'b1;
    dc = 0;
    repeat (7) begin
      @(negedge clk);
      dc++;
      start = 1'b0;
    end
    memGnt = 1'b0;
    @(negedge clk);
    check_val("wb_stall_req", {memReq, memWrEn}, 2'b10);
    check_val("wb_stall_addr", memAddr, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("wbrst_ctrl", {busy, done, memReq, memRdEn, memWrEn, errSticky}, 0);
    check_val("wbrst_addr", {memAddr, lastErrAddr}, 0);
    check_val("wbrst_wdata", memWrData, 0);
    check_val("wbrst_cnt", {corrCnt, uncorrCnt}, 0);
    check_val("wbrst_wr", n_wr, 0);
    rst = 1'b0;
    memGnt = 1'b1;
    run_sweep(-1, 1'b0, dc);
    check_val("restart_first_rd", rd_log[0], 0);
    check_val("restart_done_cyc", dc, 18);
    check_val("restart_wr_addr", last_wr_addr, 1);
    check_val("restart_ram1", ram[1], orig[1]);
    check_val("restart_corr", corrCnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
